// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Contents:
//   - address and data width constants
//   - controller state enum (also exported on the debug port)
//   - latched miss request record
//   - helpers that derive tag and way-index widths from the module parameters
package icache_pkg;

  localparam int ADDR_W  = 32;  // byte address width
  localparam int WADDR_W = 30;  // word address width (byte address bits 31:2)
  localparam int DATA_W  = 32;  // instruction word width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } icache_state_e;

  // The missing word address is captured when a miss is accepted.
  // Tag, set and word offset are sliced from it during the refill.
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
  } line_req_t;

  function automatic int tag_w(input int set_bits, input int word_bits);
    return WADDR_W - set_bits - word_bits;
  endfunction

  // A one-way cache still gets a 1-bit way index, so that no array
  // index is ever zero width.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection for a single set.
// Ports:
//   valid - valid bit of each way in the set
//   ptr   - the set's round-robin pointer
//   way   - chosen victim: the lowest-index invalid way if there is one,
//           otherwise the round-robin pointer. A one-way cache always
//           selects way 0.
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] ptr,
  output logic [WAY_W-1:0] way
);

  generate
    if (WAYS == 1) begin : g_direct
      logic unused_inputs;
      assign unused_inputs = ^{valid, ptr};
      assign way = '0;
    end else begin : g_assoc
      always_comb begin
        logic found;
        found = 1'b0;
        way   = ptr;
        for (int w = 0; w < WAYS; w++) begin
          if (!found && !valid[w]) begin
            way   = WAY_W'(w);
            found = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with word-by-word line refill.
// Ports:
//   clock, reset           - single clock; synchronous active-high reset
//   reqValid/reqReady/addr - fetch request. addr is the word address (bits 31:2).
//   respValid/rdata/is_hit - fetch response. A hit responds in the accept
//                            cycle. A miss responds in RESP after the refill.
//   flush                  - invalidate all lines. It is applied at once in
//                            IDLE, or on the first IDLE cycle after the
//                            current refill completes.
//   memReq*/memResp*       - refill interface, one word per request
//   hitCount/missCount     - saturating performance counters
//   dbg_state              - current controller state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once raised, valid stays up with stable payload until that edge.
// memRespValid has no ready signal. It is consumed only in MEM_WAIT.
module icache_sa
  import icache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [WADDR_W-1:0]  addr,
  output logic                respValid,
  output logic [DATA_W-1:0]   rdata,
  output logic                is_hit,
  input  logic                flush,
  output logic                memReqValid,
  input  logic                memReqReady,
  output logic [ADDR_W-1:0]   memAddr,
  input  logic                memRespValid,
  input  logic [DATA_W-1:0]   memRdata,
  output logic [31:0]         hitCount,
  output logic [31:0]         missCount,
  output icache_state_e       dbg_state
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_W = tag_w(SET_BITS, WORD_BITS);
  localparam int WAY_W = way_w(WAYS);

  // Storage: data and tags carry no reset; only valid bits do.
  logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAY_W-1:0]  rr_q     [SETS];

  icache_state_e     state_q, state_d;
  line_req_t         req_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WORD_BITS-1:0] cnt_q;
  logic              flush_pend_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  // Address fields of the incoming request
  logic [TAG_W-1:0]     in_tag;
  logic [SET_BITS-1:0]  in_set;
  logic [WORD_BITS-1:0] in_word;
  assign in_tag  = addr[WADDR_W-1:SET_BITS+WORD_BITS];
  assign in_set  = addr[WORD_BITS +: SET_BITS];
  assign in_word = addr[WORD_BITS-1:0];

  // Address fields of the latched miss
  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_set;
  logic [WORD_BITS-1:0] req_word;
  assign req_tag  = req_q.waddr[WADDR_W-1:SET_BITS+WORD_BITS];
  assign req_set  = req_q.waddr[WORD_BITS +: SET_BITS];
  assign req_word = req_q.waddr[WORD_BITS-1:0];

  // Tag lookup for the incoming request
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[in_set][w] && (tag_mem[w][in_set] == in_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  logic [DATA_W-1:0] hit_data, resp_data;
  assign hit_data  = data_mem[hit_way][in_set][in_word];
  assign resp_data = data_mem[victim_q][req_set][req_word];

  logic [WAY_W-1:0] victim_d;
  icache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid (valid_q[in_set]),
    .ptr   (rr_q[in_set]),
    .way   (victim_d)
  );

  // A pending flush also closes the door. Otherwise a request accepted in
  // the flush cycle would hit on a line that is being invalidated.
  logic idle_ready, accept, apply_flush, last_word, refill_beat;
  assign idle_ready  = (state_q == IDLE) && !flush && !flush_pend_q;
  assign accept      = reqValid && idle_ready;
  assign apply_flush = (state_q == IDLE) && (flush || flush_pend_q);
  assign last_word   = (cnt_q == WORD_BITS'(WORDS - 1));
  assign refill_beat = (state_q == MEM_WAIT) && memRespValid;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && !hit) state_d = MEM_REQ;
      MEM_REQ:  if (memReqReady)    state_d = MEM_WAIT;
      MEM_WAIT: if (memRespValid)   state_d = last_word ? RESP : MEM_REQ;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    reqReady    = 1'b0;
    respValid   = 1'b0;
    is_hit      = 1'b0;
    rdata       = '0;
    memReqValid = 1'b0;
    memAddr     = {req_q.waddr[WADDR_W-1:WORD_BITS], cnt_q, 2'b00};
    unique case (state_q)
      IDLE: begin
        reqReady = idle_ready;
        if (accept && hit) begin
          is_hit    = 1'b1;
          respValid = 1'b1;
          rdata     = hit_data;
        end
      end
      MEM_REQ:  memReqValid = 1'b1;
      MEM_WAIT: ;
      RESP: begin
        respValid = 1'b1;
        rdata     = resp_data;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;

  // Control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (apply_flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
        flush_pend_q <= 1'b0;
      end else if ((state_q != IDLE) && flush) begin
        flush_pend_q <= 1'b1;
      end

      if (accept) begin
        if (hit) begin
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
          cnt_q <= '0;
        end
      end

      if (refill_beat) begin
        if (last_word) valid_q[req_set][victim_q] <= 1'b1;
        else           cnt_q <= cnt_q + 1'b1;
      end

      // The comparison with WAYS-1 makes a one-way pointer stay at 0.
      if (state_q == RESP) begin
        rr_q[req_set] <= (rr_q[req_set] == WAY_W'(WAYS - 1)) ? '0
                                                             : rr_q[req_set] + 1'b1;
      end
    end
  end

  // Request latch and data/tag arrays (no reset)
  always_ff @(posedge clock) begin
    if (accept && !hit) begin
      req_q.waddr <= addr;
      victim_q    <= victim_d;
    end
    if (refill_beat && !reset) begin
      data_mem[victim_q][req_set][cnt_q] <= memRdata;
      if (last_word) tag_mem[victim_q][req_set] <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa (WAYS=2, SET_BITS=6, WORD_BITS=2).
// The bench models memory contents as a fixed function of the byte address.
// It expects each refill to request the four words of the line, in
// ascending order.
module tb_icache_sa;
  import icache_pkg::*;

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic               reqValid, reqReady, respValid, is_hit, flush;
  logic [WADDR_W-1:0] addr;
  logic [DATA_W-1:0]  rdata, memRdata;
  logic               memReqValid, memReqReady, memRespValid;
  logic [ADDR_W-1:0]  memAddr;
  logic [31:0]        hitCount, missCount;
  icache_state_e      dbg_state;

  icache_sa #(.WAYS(2), .SET_BITS(6), .WORD_BITS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .addr         (addr),
    .respValid    (respValid),
    .rdata        (rdata),
    .is_hit       (is_hit),
    .flush        (flush),
    .memReqValid  (memReqValid),
    .memReqReady  (memReqReady),
    .memAddr      (memAddr),
    .memRespValid (memRespValid),
    .memRdata     (memRdata),
    .hitCount     (hitCount),
    .missCount    (missCount),
    .dbg_state    (dbg_state)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] baddr);
    return {baddr[15:0] ^ 16'h5A5A, baddr[15:0]};
  endfunction

  // Driver: one fetch. For a miss it also serves the refill. stall holds
  // memReqReady low on the first refill request. flush_mid pulses flush in
  // the first MEM_WAIT cycle.
  task automatic do_read(input string name, input logic [31:0] baddr, input bit exp_hit,
                         input int stall, input bit flush_mid,
                         input logic [31:0] exp_hits, input logic [31:0] exp_misses);
    logic [31:0] exp_data, a0, got;
    bit first, done;
    int budget;
    exp_data = mem_word({baddr[31:2], 2'b00});
    @(negedge clock);
    reqValid = 1'b1;
    addr     = baddr[31:2];
    #1;
    check({name, ".ready"}, 32'(reqReady), 32'd1);
    check({name, ".is_hit"}, 32'(is_hit), 32'(exp_hit));
    check({name, ".respValid"}, 32'(respValid), 32'(exp_hit));
    if (exp_hit) begin
      check({name, ".hit_rdata"}, rdata, exp_data);
      check({name, ".no_memreq"}, 32'(memReqValid), 32'd0);
    end else begin
      for (int w = 0; w < 4; w++) exp_q.push_back({baddr[31:4], 4'(w * 4)});
    end
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    if (!exp_hit) begin
      first  = 1'b1;
      done   = 1'b0;
      budget = 100;
      while (!done && budget > 0) begin
        #1;
        budget--;
        if (respValid) begin
          check({name, ".miss_rdata"}, rdata, exp_data);
          check({name, ".resp_is_hit"}, 32'(is_hit), 32'd0);
          done = 1'b1;
        end else if (memReqValid) begin
          if (first && stall > 0) begin
            a0 = memAddr;
            repeat (stall) begin
              @(posedge clock);
              @(negedge clock);
              #1;
              check({name, ".stall_addr"}, memAddr, a0);
              check({name, ".stall_state"}, 32'(dbg_state), 32'(MEM_REQ));
            end
          end
          got = memAddr;
          if (exp_q.size() == 0) check({name, ".extra_memreq"}, got, 32'hDEAD_BEEF);
          else                   check({name, ".memAddr"}, got, exp_q.pop_front());
          memReqReady = 1'b1;
          @(posedge clock);
          @(negedge clock);
          memReqReady  = 1'b0;
          memRespValid = 1'b1;
          memRdata     = mem_word(got);
          if (flush_mid && first) flush = 1'b1;
          @(posedge clock);
          @(negedge clock);
          memRespValid = 1'b0;
          flush        = 1'b0;
          first        = 1'b0;
        end else begin
          @(posedge clock);
          @(negedge clock);
        end
      end
      if (!done) check({name, ".resp_timeout"}, 32'd0, 32'd1);
      check({name, ".refill_words_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clock);
      @(negedge clock);
    end
    #1;
    check({name, ".hitCount"}, hitCount, exp_hits);
    check({name, ".missCount"}, missCount, exp_misses);
  endtask

  typedef struct {
    string       name;
    logic [31:0] baddr;
    bit          exp_hit;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Set 0 holds 0x1000/0x2000/0x3000. The round-robin pointer starts at 0
    // and moves 0->1 after the 0x1000 refill and 1->0 after the 0x2000
    // refill. So 0x3000 evicts way 0 (0x1000), and the next 0x1000 evicts
    // way 1 (0x2000).
    vecs[0] = '{"cold_1004",  32'h1004, 1'b0, 32'd0, 32'd1};
    vecs[1] = '{"hit_1008",   32'h1008, 1'b1, 32'd1, 32'd1};
    vecs[2] = '{"hit_1000",   32'h1000, 1'b1, 32'd2, 32'd1};
    vecs[3] = '{"miss_2000",  32'h2000, 1'b0, 32'd2, 32'd2};
    vecs[4] = '{"evict_3000", 32'h3000, 1'b0, 32'd2, 32'd3};
    vecs[5] = '{"hit_2004",   32'h2004, 1'b1, 32'd3, 32'd3};
    vecs[6] = '{"remiss_1000",32'h1000, 1'b0, 32'd3, 32'd4};
    vecs[7] = '{"hit_300c",   32'h300C, 1'b1, 32'd4, 32'd4};
    vecs[8] = '{"miss_4ff0",  32'h4FF0, 1'b0, 32'd4, 32'd5};
    vecs[9] = '{"hit_4ffc",   32'h4FFC, 1'b1, 32'd5, 32'd5};

    reset = 1'b1; reqValid = 1'b0; addr = '0; flush = 1'b0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst.reqReady", 32'(reqReady), 32'd1);
    check("rst.respValid", 32'(respValid), 32'd0);
    check("rst.is_hit", 32'(is_hit), 32'd0);
    check("rst.memReqValid", 32'(memReqValid), 32'd0);
    check("rst.hitCount", hitCount, 32'd0);
    check("rst.missCount", missCount, 32'd0);
    check("rst.state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 10; i++)
      do_read(vecs[i].name, vecs[i].baddr, vecs[i].exp_hit, 0, 1'b0,
              vecs[i].exp_hits, vecs[i].exp_misses);

    // Backpressure on the first refill request (set 4)
    do_read("bp_5040", 32'h5040, 1'b0, 5, 1'b0, 32'd5, 32'd6);
    do_read("bp_hit_5048", 32'h5048, 1'b1, 0, 1'b0, 32'd6, 32'd6);

    // Flush during MEM_WAIT: the response still completes, and the first
    // IDLE cycle after it applies the flush.
    do_read("flush_mid", 32'h6080, 1'b0, 0, 1'b1, 32'd6, 32'd7);
    check("flush_mid.ready_blocked", 32'(reqReady), 32'd0);
    check("flush_mid.state", 32'(dbg_state), 32'(IDLE));
    do_read("after_flush_6080", 32'h6080, 1'b0, 0, 1'b0, 32'd6, 32'd8);
    do_read("after_flush_1000", 32'h1000, 1'b0, 0, 1'b0, 32'd6, 32'd9);
    do_read("hit_1004", 32'h1004, 1'b1, 0, 1'b0, 32'd7, 32'd9);

    // Flush in IDLE alongside a request that would hit
    @(negedge clock);
    flush = 1'b1; reqValid = 1'b1; addr = 30'(32'h1004 >> 2);
    #1;
    check("idle_flush.reqReady", 32'(reqReady), 32'd0);
    check("idle_flush.is_hit", 32'(is_hit), 32'd0);
    check("idle_flush.respValid", 32'(respValid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0; reqValid = 1'b0;
    do_read("idle_flush_miss", 32'h1004, 1'b0, 0, 1'b0, 32'd7, 32'd10);

    // Reset mid-refill, followed by a late memory response
    @(negedge clock);
    reqValid = 1'b1; addr = 30'(32'h7000 >> 2);
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    #1;
    check("rst_mid.memReqValid", 32'(memReqValid), 32'd1);
    memReqReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    memReqReady = 1'b0;
    #1;
    check("rst_mid.in_wait", 32'(dbg_state), 32'(MEM_WAIT));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid.state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid.hitCount", hitCount, 32'd0);
    check("rst_mid.missCount", missCount, 32'd0);
    check("rst_mid.reqReady", 32'(reqReady), 32'd1);
    memRespValid = 1'b1; memRdata = $urandom;
    #1;
    check("rst_mid.late_respValid", 32'(respValid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    memRespValid = 1'b0;
    #1;
    check("rst_mid.late_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid.late_memReq", 32'(memReqValid), 32'd0);
    do_read("rst_mid_remiss", 32'h7000, 1'b0, 0, 1'b0, 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SET_BITS, default 6, log2 of the set count.
REQ-003 SHALL have parameter WORD_BITS, default 2, log2 of the 32-bit words per line.
REQ-004 SHALL have port clock, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port reqValid, input, 1, fetch request.
REQ-007 SHALL have port reqReady, output, 1, cache can accept a request.
REQ-008 SHALL have port addr, input, 30 (bits 31:2), word address.
REQ-009 SHALL have port respValid, output, 1, rdata valid.
REQ-010 SHALL have port rdata, output, 32, fetched instruction word.
REQ-011 SHALL have port is_hit, output, 1, accepted request hit this cycle.
REQ-012 SHALL have port flush, input, 1, invalidate all lines.
REQ-013 SHALL have port memReqValid, output, 1, refill word request.
REQ-014 SHALL have port memReqReady, input, 1, memory accepts the request.
REQ-015 SHALL have port memAddr, output, 32, byte address of the refill word, bits 1:0 = 0.
REQ-016 SHALL have port memRespValid, input, 1, refill data valid.
REQ-017 SHALL have port memRdata, input, 32, refill word.
REQ-018 SHALL have ports hitCount and missCount, output, 32 each, saturating performance counters.

Function
REQ-019 Address split SHALL be tag = addr[31:2+SET_BITS+WORD_BITS], set = next SET_BITS bits, word = addr[2+WORD_BITS-1:2].
REQ-020 FSM states SHALL be IDLE, MEM_REQ, MEM_WAIT, RESP.
REQ-021 reqReady SHALL be 1 only in IDLE with flush=0.
REQ-022 In IDLE, a request (reqValid && reqReady) whose tag matches a valid way of its set SHALL assert is_hit=1 and respValid=1 with that word on rdata in the same cycle; 0-cycle hit latency.
REQ-023 On a miss in IDLE, the block SHALL latch addr, select victim way = the first invalid way (lowest index), else the set's round-robin pointer, clear the refill word counter, and go to MEM_REQ; is_hit=0, respValid=0.
REQ-024 In MEM_REQ, memReqValid=1 and memAddr = {latched tag, set, counter, 2'b00}; when memReqReady=1, go to MEM_WAIT.
REQ-025 In MEM_WAIT, on memRespValid=1, memRdata SHALL be written to the victim way at the counter word; if the counter is not last, increment it and return to MEM_REQ; else set the victim's valid bit and tag and go to RESP.
REQ-026 Refill SHALL start at word 0 and wrap nowhere; it always fetches all 2^WORD_BITS words in ascending order.
REQ-027 In RESP, respValid=1, is_hit=0, rdata = refilled word at the latched word offset; the set's round-robin pointer SHALL advance modulo WAYS; next state IDLE.
REQ-028 memRespValid outside MEM_WAIT SHALL be ignored.
REQ-029 flush in IDLE SHALL clear all valid bits and round-robin pointers in one cycle; any reqValid that cycle is not accepted.
REQ-030 flush outside IDLE SHALL be recorded and applied on the first IDLE cycle after RESP; the in-flight response completes normally.
REQ-031 hitCount SHALL increment on each hit and missCount on each miss, both saturating at 2^32-1.
REQ-032 With WAYS=1, victim selection SHALL reduce to way 0 (direct-mapped).

Reset
REQ-033 On reset, the FSM SHALL enter IDLE, all valid bits, round-robin pointers, the refill counter, the pending-flush flag, hitCount and missCount SHALL clear.
REQ-034 Reset SHALL override any state, including mid-refill; no memory response is consumed afterwards.
REQ-035 Reset values: reqReady=1, respValid=0, is_hit=0, memReqValid=0, rdata, memAddr and the data/tag arrays don't-care.

Structure
REQ-036 The state enum, line/tag struct and address-field width constants SHALL live in package icache_pkg.
REQ-037 Per-set victim selection SHALL be a sub-module icache_victim_sel (valid vector + pointer -> way index).
REQ-038 Data and tag arrays SHALL be plain registers without reset; only valid bits and control registers reset.

Verification
REQ-039 Cold miss: WAYS=2, WORD_BITS=2, read 0x1004 -> four memReq at 0x1000..0x100C, RESP rdata = word at 0x1004, missCount=1.
REQ-040 Hit: repeat read 0x1008 -> is_hit=1 and respValid=1 in the same cycle, memReqValid stays 0, hitCount=1.
REQ-041 Conflict: read 0x1000, 0x2000, 0x3000 (same set 0) -> third evicts way 0; 0x2000 still hits, 0x1000 misses.
REQ-042 Backpressure: hold memReqReady=0 for 5 cycles in MEM_REQ -> memAddr stable, no state advance, refill completes afterwards.
REQ-043 Flush: flush during MEM_WAIT -> refill response delivered, then all lines invalid; next read of the same address misses.
REQ-044 Reset mid-refill: reset in MEM_WAIT -> next cycle IDLE, counters 0, a late memRespValid ignored.
